// File: rtl/game_sequencer.sv
// Round/lifecycle controller for the ballplayer game: key debounce, home-position latch,
// game FSM, score and lives. Optional ARMED auto-release: define GAME_SEQUENCER_AUTO_RELEASE_EN.
module game_sequencer #(
    parameter int DEB_CYCLES = 240000,
    parameter int LIVES      = 3,
    parameter int SCORE_MAX  = 99,
    parameter int AUTO_DLY   = 36000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       release_btn,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    input  logic       bounce_evt,
    input  logic       stop_flag,
    input  logic       over_flag,
    output logic [8:0] home_pos,
    output logic       ball_release,
    output logic       play_en,
    output logic [2:0] state,
    output logic [6:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_PLAY    = 3'd2,
        S_STOPPED = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam int DCW = $clog2(DEB_CYCLES + 1);

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_sync;
    logic [DCW-1:0] r_deb_cnt;
    logic           r_press;
    logic           r_stop_q, r_over_q;
    logic [6:0]     r_score, w_score_nxt;
    logic [1:0]     r_lives, w_lives_nxt;
    logic [8:0]     r_home;
    logic           r_release, w_release_nxt;
    logic           w_stop_rise, w_over_rise, w_auto_fire;
    logic [16:0]    w_prod;
    logic [8:0]     w_home;

    // Synchroniser resets to the idle (released) level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_deb_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], release_btn};
            r_press <= ~r_sync[1] && (r_deb_cnt == DCW'(DEB_CYCLES - 1));
            if (r_sync[1])
                r_deb_cnt <= '0;
            else if (r_deb_cnt != DCW'(DEB_CYCLES))
                r_deb_cnt <= r_deb_cnt + DCW'(1);
        end
    end

`ifdef GAME_SEQUENCER_AUTO_RELEASE_EN
    localparam int ACW = $clog2(AUTO_DLY + 1);
    logic [ACW-1:0] r_auto_cnt;

    // Held at zero outside ARMED, so every entry into ARMED starts a fresh delay.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_ARMED)
            r_auto_cnt <= '0;
        else if (r_auto_cnt != ACW'(AUTO_DLY))
            r_auto_cnt <= r_auto_cnt + ACW'(1);
    end

    assign w_auto_fire = (r_state == S_ARMED) && (r_auto_cnt == ACW'(AUTO_DLY));
`else
    // Feature compiled out: constant-false expression keeps AUTO_DLY referenced.
    assign w_auto_fire = (AUTO_DLY < 0);
`endif

    assign w_stop_rise = stop_flag & ~r_stop_q;
    assign w_over_rise = over_flag & ~r_over_q;
    assign w_prod      = {9'd0, adc_data} * 17'd310;
    assign w_home      = w_prod[16:8] + 9'd7;

    always_comb begin
        w_state_nxt   = r_state;
        w_score_nxt   = r_score;
        w_lives_nxt   = r_lives;
        w_release_nxt = 1'b0;
        case (r_state)
            S_IDLE:    if (r_press) w_state_nxt = S_ARMED;
            S_ARMED: begin
                if (r_press || w_auto_fire) begin
                    w_state_nxt   = S_PLAY;
                    w_release_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                if (bounce_evt && r_score != 7'(SCORE_MAX))
                    w_score_nxt = r_score + 7'd1;
                if (w_over_rise) begin
                    if (r_lives <= 2'd1) begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_OVER;
                    end else begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_state_nxt = S_ARMED;
                    end
                end else if (w_stop_rise) begin
                    w_state_nxt = S_STOPPED;
                end
            end
            S_STOPPED: if (r_press) w_state_nxt = S_ARMED;
            S_OVER: begin
                if (r_press) begin
                    w_state_nxt = S_IDLE;
                    w_score_nxt = 7'd0;
                    w_lives_nxt = 2'(LIVES);
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_score   <= 7'd0;
            r_lives   <= 2'(LIVES);
            r_home    <= 9'd7;
            r_release <= 1'b0;
            r_stop_q  <= 1'b0;
            r_over_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_score   <= w_score_nxt;
            r_lives   <= w_lives_nxt;
            r_release <= w_release_nxt;
            r_stop_q  <= stop_flag;
            r_over_q  <= over_flag;
            if (adc_done && (r_state == S_IDLE || r_state == S_ARMED || r_state == S_STOPPED))
                r_home <= w_home;
        end
    end

    assign home_pos     = r_home;
    assign ball_release = r_release;
    assign play_en      = (r_state == S_PLAY);
    assign game_over    = (r_state == S_OVER);
    assign state        = r_state;
    assign score        = r_score;
    assign lives        = r_lives;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues hand-computed snapshots and release strobes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_sequencer;

    logic       clk = 1'b0, rst = 1'b1, release_btn = 1'b1, adc_done = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic       bounce_evt = 1'b0, stop_flag = 1'b0, over_flag = 1'b0;
    logic [8:0] home_pos;
    logic       ball_release, play_en, game_over;
    logic [2:0] state;
    logic [6:0] score;
    logic [1:0] lives;

    always #5 clk = ~clk;

    game_sequencer #(.DEB_CYCLES(8), .LIVES(3), .SCORE_MAX(99), .AUTO_DLY(1000)) dut (
        .clk(clk), .rst(rst), .release_btn(release_btn), .adc_done(adc_done),
        .adc_data(adc_data), .bounce_evt(bounce_evt), .stop_flag(stop_flag),
        .over_flag(over_flag), .home_pos(home_pos), .ball_release(ball_release),
        .play_en(play_en), .state(state), .score(score), .lives(lives), .game_over(game_over)
    );

    typedef struct packed {
        int         cyc;
        logic [2:0] st;
        logic [6:0] sc;
        logic [1:0] lv;
        logic [8:0] hm;
        logic       pe;
        logic       go;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    rel_q[$];
    int    cyc = 0, n_tests = 0, n_fail = 0;

    logic [2:0] e_st = 3'd0;
    logic [6:0] e_sc = 7'd0;
    logic [1:0] e_lv = 2'd3;
    logic [8:0] e_hm = 9'd7;
    logic       e_pe = 1'b0, e_go = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every snapshot due this cycle, and every release strobe the DUT emits.
    initial forever begin
        exp_t  e;
        string nm;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (e.cyc != cyc || state !== e.st || score !== e.sc || lives !== e.lv ||
                home_pos !== e.hm || play_en !== e.pe || game_over !== e.go) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got st=%0d sc=%0d lv=%0d hm=%0d pe=%0b go=%0b, want st=%0d sc=%0d lv=%0d hm=%0d pe=%0b go=%0b",
                         nm, cyc, state, score, lives, home_pos, play_en, game_over,
                         e.st, e.sc, e.lv, e.hm, e.pe, e.go);
            end
        end
        while (rel_q.size() > 0 && rel_q[0] < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL release_missing: no strobe at cyc %0d, want one", rel_q.pop_front());
        end
        if (ball_release === 1'b1) begin
            n_tests++;
            if (rel_q.size() > 0 && rel_q[0] == cyc) begin
                void'(rel_q.pop_front());
            end else begin
                n_fail++;
                $display("FAIL release_unexpected: got strobe at cyc %0d, want none", cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm);
        exp_q.push_back('{cyc: cyc, st: e_st, sc: e_sc, lv: e_lv, hm: e_hm, pe: e_pe, go: e_go});
        name_q.push_back(nm);
    endtask

    // Hold the key low until the FSM has acted (DEB+3 edges), then release and let the counter clear.
    task automatic press_key(input bit exp_rel);
        release_btn = 1'b0;
        tick(11);
        if (exp_rel) rel_q.push_back(cyc);
        release_btn = 1'b1;
        tick(4);
    endtask

    task automatic adc(input logic [7:0] v);
        adc_data = v;
        adc_done = 1'b1;
        tick(1);
        adc_done = 1'b0;
    endtask

    initial begin
        tick(2);
        snap("reset");
        rst = 1'b0;
        tick(1);

        release_btn = 1'b0; tick(5); release_btn = 1'b1; tick(10);
        snap("glitch_no_press");

        adc(8'd0);   e_hm = 9'd7;   snap("home_0");
        adc(8'd128); e_hm = 9'd162; snap("home_128");
        adc(8'd255); e_hm = 9'd315; snap("home_255");

        release_btn = 1'b0; tick(10);
        snap("deb_before");
        tick(1); e_st = 3'd1;
        snap("deb_armed");
        tick(9); release_btn = 1'b1; tick(4);
        snap("deb_once");
        adc(8'd128); e_hm = 9'd162; snap("home_armed");

        press_key(1); e_st = 3'd2; e_pe = 1'b1; snap("play_entry");
        adc(8'd0); snap("home_frozen_play");
        bounce_evt = 1'b1; tick(3); bounce_evt = 1'b0; e_sc = 7'd3; snap("three_bounces");

        stop_flag = 1'b1; tick(1); stop_flag = 1'b0; e_st = 3'd3; e_pe = 1'b0; snap("stop");
        tick(1);
        bounce_evt = 1'b1; tick(1); bounce_evt = 1'b0; snap("bounce_ignored_stopped");
        press_key(0); e_st = 3'd1; snap("stopped_to_armed");
        press_key(1); e_st = 3'd2; e_pe = 1'b1; snap("play2");

        bounce_evt = 1'b1; over_flag = 1'b1; tick(1); bounce_evt = 1'b0; over_flag = 1'b0;
        e_sc = 7'd4; e_lv = 2'd2; e_st = 3'd1; e_pe = 1'b0; snap("bounce_with_over");
        tick(1);
        press_key(1); e_st = 3'd2; e_pe = 1'b1; snap("play3");

        over_flag = 1'b1; stop_flag = 1'b1; tick(1); over_flag = 1'b0; stop_flag = 1'b0;
        e_lv = 2'd1; e_st = 3'd1; e_pe = 1'b0; snap("over_beats_stop");
        tick(1);
        press_key(1); e_st = 3'd2; e_pe = 1'b1; snap("play4");

        bounce_evt = 1'b1; tick(95); e_sc = 7'd99; snap("score_99");
        tick(2); snap("score_saturated");
        over_flag = 1'b1; tick(1); bounce_evt = 1'b0; over_flag = 1'b0;
        e_lv = 2'd0; e_st = 3'd4; e_pe = 1'b0; e_go = 1'b1; snap("game_over");
        bounce_evt = 1'b1; tick(1); bounce_evt = 1'b0;
        adc(8'd255); snap("over_frozen");
        press_key(0); e_st = 3'd0; e_sc = 7'd0; e_lv = 2'd3; e_go = 1'b0; snap("restart");

        press_key(0); e_st = 3'd1; snap("armed_again");
        adc(8'd255); e_hm = 9'd315; snap("home_armed_255");
        press_key(1); e_st = 3'd2; e_pe = 1'b1;
        bounce_evt = 1'b1; tick(2); bounce_evt = 1'b0; e_sc = 7'd2; snap("pre_reset");
        rst = 1'b1; tick(1);
        e_st = 3'd0; e_sc = 7'd0; e_lv = 2'd3; e_hm = 9'd7; e_pe = 1'b0; snap("mid_play_reset");
        rst = 1'b0; tick(3); snap("post_reset");

        tick(5);
        if (exp_q.size() > 0 || rel_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d snapshots and %0d strobes pending, want 0", exp_q.size(), rel_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Round/lifecycle controller for the ballplayer game; runs in the 12 MHz `clk` domain beside the ball-motion block.
- Debounces the ball-release key and latches the ADC-derived home position, freezing it for the duration of a round.
- Owns the game FSM (idle/armed/play/stopped/over), issues the release pulse and play enable to the ball-motion block, and keeps score and lives for display.

Parameters:
- DEB_CYCLES, 240000, stable-low cycles on the synchronised key before a press is accepted (20 ms @ 12 MHz).
- LIVES, 3, lives loaded at game start (1..3).
- SCORE_MAX, 99, score saturation value.
- AUTO_DLY, 36000000, ARMED auto-release delay in cycles (optional feature only).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  synchronous reset, active-high.
- release_btn  in  1  raw ball-release key, active-low, asynchronous.
- adc_done  in  1  one-cycle pulse: adc_data valid.
- adc_data  in  8  ADC sample.
- bounce_evt  in  1  one-cycle pulse per successful hand hit.
- stop_flag  in  1  level: ball at rest.
- over_flag  in  1  level: ball lost.
- home_pos  out  9  latched ball home position.
- ball_release  out  1  one-cycle release strobe.
- play_en  out  1  high only in PLAY.
- state  out  3  IDLE=0, ARMED=1, PLAY=2, STOPPED=3, OVER=4.
- score  out  7  0..SCORE_MAX.
- lives  out  2  remaining lives.
- game_over  out  1  high only in OVER.

Behaviour:
- Reset values (rst high at a clk edge): state=IDLE; score=0; lives=LIVES; home_pos=7; ball_release=0; play_en=0; game_over=0; debounce counter=0; edge registers=0.
- Key path:
  - 2-flop synchroniser feeds a counter that increments while the synchronised key is 0 and clears when it is 1.
  - `press` pulses for exactly one cycle when the counter reaches DEB_CYCLES. The counter then holds at DEB_CYCLES, so only one press is generated per hold.
  - Latency from a stable raw low to `press` is DEB_CYCLES+2 cycles. The FSM acts on the following edge.
- Home latch:
  - In IDLE, ARMED and STOPPED, each adc_done registers home_pos = ((adc_data*310)>>8)+7.
  - Use a full 17-bit product; the result range is 7..315 and fits in 9 bits.
  - home_pos is frozen in PLAY and OVER.
- stop_flag and over_flag are rising-edge detected from registered copies; the edge registers update every cycle.
- FSM transitions:
  - IDLE: press -> ARMED.
  - ARMED: press -> PLAY, with ball_release=1 for the single transition cycle.
  - PLAY: play_en=1.
    - bounce_evt -> score+1, saturating at SCORE_MAX.
    - over_flag rise: if lives==1 -> lives=0, go to OVER; else lives-1, go to ARMED.
    - else stop_flag rise -> STOPPED.
    - over has priority over stop.
    - A bounce_evt in the same cycle as over/stop is still counted.
    - press is ignored.
  - STOPPED: press -> ARMED; no life lost; score held.
  - OVER: game_over=1, score and lives held; press -> IDLE, loading score=0 and lives=LIVES.
- bounce_evt outside PLAY is ignored. Pulses arriving while a press is pending are not queued.
- rst asserted mid-round returns to the reset values on the next edge, with no ball_release glitch.
- Illegal state codes recover to IDLE.

Optional Feature:
- Macro: GAME_SEQUENCER_AUTO_RELEASE_EN.
- Defined:
  - A counter runs in ARMED, cleared on entry.
  - When it reaches AUTO_DLY with no press, the FSM enters PLAY with the same one-cycle ball_release.
  - A press before then behaves as normal.
- Undefined: the counter logic is absent and ARMED exits on press only.

Test Plan:
- Debounce (DEB_CYCLES=8): 5-cycle low glitch -> no press, state stays 0. 20-cycle low -> state 0->1 at cycle 11 after the low, exactly once.
- Home latch:
  - adc_data 0/128/255 with adc_done in IDLE -> home_pos 7/162/315.
  - adc_done in PLAY with 0 -> home_pos unchanged.
- Full round: press, press -> ball_release high one cycle, play_en=1, state=2. Three bounce_evt -> score=3. stop_flag rise -> state=3, lives=3.
- Lives (LIVES=3): three over_flag rises across rounds -> lives 2, 1, 0; the third gives state=4 and game_over=1. Press -> state=0, score=0, lives=3.
- Saturation / simultaneity:
  - Score preset at 99 via 99 bounces, then a bounce -> score stays 99.
  - bounce_evt together with an over_flag rise -> score+1 (unless already 99) and lives-1, same edge.
  - over_flag and stop_flag rising together -> ARMED or OVER, not STOPPED.
- Reset mid-PLAY: rst high for 1 cycle -> next edge state=0, score=0, lives=3, play_en=0, home_pos=7.
